// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the hazard / forwarding unit.
//   fsm_state_e   : load-use sequencing state
//   REG_IDX_W     : architectural register index width
//   OPC_*         : major opcodes used by the pipeline stages to derive we / is_load
package hazard_fwd_unit_pkg;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_LU_WAIT = 1'b1
    } fsm_state_e;

    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        return (opc != OPC_STORE) && (opc != OPC_BRANCH);
    endfunction

    function automatic logic opc_is_load(input logic [6:0] opc);
        return opc == OPC_LOAD;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_mux_slot.sv
// Per-source-operand forwarding slot.
// Purpose: match one decode source index against the exe and acc writers,
// select the youngest valid producer, and flag a load-use hazard.
// Ports:
//   de_valid_i, rs_i, rf_data_i          decode source and register-file data
//   exe_*_i, acc_*_i                     writer stage status, index and data
//   acc_dvld_i                           load data present on acc_data_i
//   fwd_data_o                           selected operand
//   hazard_o                             this slot must stall
//   exe_lu_hit_o                         hazard is caused by a load in exe
module fwd_mux_slot
    import hazard_fwd_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 de_valid_i,
    input  logic [REG_IDX_W-1:0] rs_i,
    input  logic [XLEN-1:0]      rf_data_i,
    input  logic                 exe_valid_i,
    input  logic                 exe_we_i,
    input  logic                 exe_is_load_i,
    input  logic [REG_IDX_W-1:0] exe_rd_i,
    input  logic [XLEN-1:0]      exe_data_i,
    input  logic                 acc_valid_i,
    input  logic                 acc_we_i,
    input  logic                 acc_is_load_i,
    input  logic [REG_IDX_W-1:0] acc_rd_i,
    input  logic [XLEN-1:0]      acc_data_i,
    input  logic                 acc_dvld_i,
    output logic [XLEN-1:0]      fwd_data_o,
    output logic                 hazard_o,
    output logic                 exe_lu_hit_o
);

    logic rs_nz;
    logic match_exe;
    logic match_acc;

    // x0 is hard-wired zero, so it never matches a writer.
    assign rs_nz     = (rs_i != '0);
    assign match_exe = exe_valid_i && exe_we_i && (exe_rd_i == rs_i) && rs_nz;
    assign match_acc = acc_valid_i && acc_we_i && (acc_rd_i == rs_i) && rs_nz;

    assign exe_lu_hit_o = de_valid_i && match_exe && exe_is_load_i;

    // An acc load still waiting for dmem only matters if exe does not shadow it.
    assign hazard_o = exe_lu_hit_o ||
                      (de_valid_i && match_acc && acc_is_load_i && !acc_dvld_i && !match_exe);

    always_comb begin
        fwd_data_o = rf_data_i;
        if (match_exe && !exe_is_load_i) begin
            fwd_data_o = exe_data_i;
        end else if (match_acc) begin
            fwd_data_o = acc_data_i;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the decode -> execute boundary.
// Purpose: forward exe/acc results into the execute operand register, stall
// decode on load-use hazards, and count stalled cycles.
// Ports:
//   clk, rst (async, active-low), flush
//   de_valid, de_rs, de_rf_data           decode sources
//   exe_*, acc_*, acc_dvld                writer stages
//   stall                                  combinational freeze of PC / decode
//   op_q, op_vld_q                         registered execute operands / valid
//   stall_cnt                              saturating stalled-cycle count
//
// state    | meaning
// ST_RUN     | no load-use hazard outstanding
// ST_LU_WAIT | stalled behind a load that was in exe, waiting for its data
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NSRC = 2,
    parameter int CNTW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     de_valid,
    input  logic [NSRC*REG_IDX_W-1:0] de_rs,
    input  logic [NSRC*XLEN-1:0]     de_rf_data,
    input  logic                     exe_valid,
    input  logic                     exe_we,
    input  logic                     exe_is_load,
    input  logic [REG_IDX_W-1:0]     exe_rd,
    input  logic [XLEN-1:0]          exe_data,
    input  logic                     acc_valid,
    input  logic                     acc_we,
    input  logic                     acc_is_load,
    input  logic [REG_IDX_W-1:0]     acc_rd,
    input  logic [XLEN-1:0]          acc_data,
    input  logic                     acc_dvld,
    output logic                     stall,
    output logic [NSRC*XLEN-1:0]     op_q,
    output logic                     op_vld_q,
    output logic [CNTW-1:0]          stall_cnt
);

    logic [NSRC*XLEN-1:0] fwd_ops;
    logic [NSRC-1:0]      slot_hazard;
    logic [NSRC-1:0]      slot_exe_lu;
    logic                 exe_lu;

    fsm_state_e state_q, state_d;

    logic [NSRC*XLEN-1:0] op_d;
    logic                 op_vld_d;
    logic [CNTW-1:0]      stall_cnt_d;

    for (genvar i = 0; i < NSRC; i++) begin : g_slot
        fwd_mux_slot #(.XLEN(XLEN)) u_slot (
            .de_valid_i    (de_valid),
            .rs_i          (de_rs[i*REG_IDX_W +: REG_IDX_W]),
            .rf_data_i     (de_rf_data[i*XLEN +: XLEN]),
            .exe_valid_i   (exe_valid),
            .exe_we_i      (exe_we),
            .exe_is_load_i (exe_is_load),
            .exe_rd_i      (exe_rd),
            .exe_data_i    (exe_data),
            .acc_valid_i   (acc_valid),
            .acc_we_i      (acc_we),
            .acc_is_load_i (acc_is_load),
            .acc_rd_i      (acc_rd),
            .acc_data_i    (acc_data),
            .acc_dvld_i    (acc_dvld),
            .fwd_data_o    (fwd_ops[i*XLEN +: XLEN]),
            .hazard_o      (slot_hazard[i]),
            .exe_lu_hit_o  (slot_exe_lu[i])
        );
    end

    // Gated by rst so every output reads zero while reset is held.
    assign stall  = (|slot_hazard) && !flush && rst;
    assign exe_lu = |slot_exe_lu;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        op_vld_d    = 1'b0;
        stall_cnt_d = stall_cnt;

        unique case (state_q)
            ST_RUN:     if (stall && exe_lu) state_d = ST_LU_WAIT;
            ST_LU_WAIT: if (!stall)          state_d = ST_RUN;
            default:                         state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_RUN;

        if (!flush && !stall) begin
            op_d     = fwd_ops;
            op_vld_d = de_valid;
        end

        if (stall && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt_d = stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_RUN;
            op_q      <= '0;
            op_vld_q  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op_vld_q  <= op_vld_d;
            stall_cnt <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    localparam int XLEN = 32;
    localparam int NSRC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            de_valid;
    logic [9:0]      de_rs;
    logic [63:0]     de_rf_data;
    logic            exe_valid, exe_we, exe_is_load;
    logic [4:0]      exe_rd;
    logic [31:0]     exe_data;
    logic            acc_valid, acc_we, acc_is_load;
    logic [4:0]      acc_rd;
    logic [31:0]     acc_data;
    logic            acc_dvld;

    logic            stall, stall2;
    logic [63:0]     op_q, op_q2;
    logic            op_vld_q, op_vld_q2;
    logic [15:0]     stall_cnt;
    logic [1:0]      stall_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.XLEN(XLEN), .NSRC(NSRC), .CNTW(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .de_valid(de_valid), .de_rs(de_rs), .de_rf_data(de_rf_data),
        .exe_valid(exe_valid), .exe_we(exe_we), .exe_is_load(exe_is_load),
        .exe_rd(exe_rd), .exe_data(exe_data),
        .acc_valid(acc_valid), .acc_we(acc_we), .acc_is_load(acc_is_load),
        .acc_rd(acc_rd), .acc_data(acc_data), .acc_dvld(acc_dvld),
        .stall(stall), .op_q(op_q), .op_vld_q(op_vld_q), .stall_cnt(stall_cnt)
    );

    hazard_fwd_unit #(.XLEN(XLEN), .NSRC(NSRC), .CNTW(2)) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .de_valid(de_valid), .de_rs(de_rs), .de_rf_data(de_rf_data),
        .exe_valid(exe_valid), .exe_we(exe_we), .exe_is_load(exe_is_load),
        .exe_rd(exe_rd), .exe_data(exe_data),
        .acc_valid(acc_valid), .acc_we(acc_we), .acc_is_load(acc_is_load),
        .acc_rd(acc_rd), .acc_data(acc_data), .acc_dvld(acc_dvld),
        .stall(stall2), .op_q(op_q2), .op_vld_q(op_vld_q2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_stages();
        flush = 0;
        exe_valid = 0; exe_we = 0; exe_is_load = 0; exe_rd = 0; exe_data = 0;
        acc_valid = 0; acc_we = 0; acc_is_load = 0; acc_rd = 0; acc_data = 0;
        acc_dvld = 0;
    endtask

    initial begin
        rst = 0;
        idle_stages();
        de_valid = 0; de_rs = 0; de_rf_data = 0;
        #12;
        check("rst_op_q", op_q, 64'h0);
        check("rst_op_vld", {63'h0, op_vld_q}, 64'h0);
        check("rst_cnt", {48'h0, stall_cnt}, 64'h0);
        check("rst_stall", {63'h0, stall}, 64'h0);
        @(negedge clk);
        rst = 1;
        step();

        // ALU result in exe forwarded to slot 0
        exe_valid = 1; exe_we = 1; exe_rd = 5; exe_data = 32'h11;
        de_valid = 1; de_rs = {5'd0, 5'd5}; de_rf_data = 64'h0;
        #1 check("alu_fwd_stall", {63'h0, stall}, 64'h0);
        step();
        check("alu_fwd_op0", {32'h0, op_q[31:0]}, 64'h11);
        check("alu_fwd_vld", {63'h0, op_vld_q}, 64'h1);

        // exe and acc both write x7: exe wins; slot 0 x9 takes rf data
        exe_rd = 7; exe_data = 32'hA;
        acc_valid = 1; acc_we = 1; acc_rd = 7; acc_data = 32'hB; acc_dvld = 1;
        de_rs = {5'd7, 5'd9}; de_rf_data = {32'h0, 32'h99};
        #1 check("prio_stall", {63'h0, stall}, 64'h0);
        step();
        check("prio_op1", {32'h0, op_q[63:32]}, 64'hA);
        check("prio_op0_rf", {32'h0, op_q[31:0]}, 64'h99);

        // only acc matches
        exe_rd = 8;
        step();
        check("acc_only_op1", {32'h0, op_q[63:32]}, 64'hB);

        // write to x0 never forwards
        idle_stages();
        exe_valid = 1; exe_we = 1; exe_rd = 0; exe_data = 32'hFF;
        de_rs = {5'd0, 5'd0}; de_rf_data = 64'h0;
        #1 check("x0_stall", {63'h0, stall}, 64'h0);
        step();
        check("x0_op0", {32'h0, op_q[31:0]}, 64'h0);

        // load-use: LW x3 in exe, then 2 cycles in acc without data
        exe_rd = 3; exe_is_load = 1; exe_data = 32'hDEAD;
        de_rs = {5'd0, 5'd3};
        #1 check("lu_stall_exe", {63'h0, stall}, 64'h1);
        step();
        check("lu_bubble1", {63'h0, op_vld_q}, 64'h0);
        check("lu_cnt1", {48'h0, stall_cnt}, 64'h1);
        idle_stages();
        acc_valid = 1; acc_we = 1; acc_is_load = 1; acc_rd = 3; acc_dvld = 0;
        #1 check("lu_stall_acc", {63'h0, stall}, 64'h1);
        step();
        check("lu_stall_acc2", {63'h0, stall}, 64'h1);
        step();
        check("lu_cnt3", {48'h0, stall_cnt}, 64'h3);
        check("lu_hold_op0", {32'h0, op_q[31:0]}, 64'h0);
        acc_dvld = 1; acc_data = 32'h55;
        #1 check("lu_release", {63'h0, stall}, 64'h0);
        step();
        check("lu_op0", {32'h0, op_q[31:0]}, 64'h55);
        check("lu_vld", {63'h0, op_vld_q}, 64'h1);
        check("lu_cnt_final", {48'h0, stall_cnt}, 64'h3);

        // load-use stall cancelled by flush
        idle_stages();
        exe_valid = 1; exe_we = 1; exe_is_load = 1; exe_rd = 4;
        de_rs = {5'd0, 5'd4}; de_rf_data = {32'h0, 32'h44};
        #1 check("fl_stall_pre", {63'h0, stall}, 64'h1);
        flush = 1;
        #1 check("fl_stall", {63'h0, stall}, 64'h0);
        step();
        check("fl_vld", {63'h0, op_vld_q}, 64'h0);
        check("fl_hold_op0", {32'h0, op_q[31:0]}, 64'h55);
        check("fl_cnt", {48'h0, stall_cnt}, 64'h3);
        idle_stages();
        step();
        check("fl_run_op0", {32'h0, op_q[31:0]}, 64'h44);
        check("fl_run_vld", {63'h0, op_vld_q}, 64'h1);

        // de_valid=0 suppresses stall and issues a bubble
        exe_valid = 1; exe_we = 1; exe_is_load = 1; exe_rd = 4;
        de_valid = 0;
        #1 check("dv0_stall", {63'h0, stall}, 64'h0);
        step();
        check("dv0_vld", {63'h0, op_vld_q}, 64'h0);

        // 5 more stall cycles: wide counter 8, 2-bit counter held at 3
        de_valid = 1; de_rs = {5'd4, 5'd0};
        for (int i = 0; i < 5; i++) step();
        check("sat_wide", {48'h0, stall_cnt}, 64'h8);
        check("sat_narrow", {62'h0, stall_cnt2}, 64'h3);

        // asynchronous reset mid-stall
        #2 rst = 0;
        #1;
        check("arst_op_q", op_q, 64'h0);
        check("arst_vld", {62'h0, op_vld_q, op_vld_q2}, 64'h0);
        check("arst_cnt", {46'h0, stall_cnt2, stall_cnt}, 64'h0);
        check("arst_stall", {62'h0, stall, stall2}, 64'h0);
        @(negedge clk);
        rst = 1;
        #1 check("post_rst_stall", {63'h0, stall}, 64'h1);
        step();
        check("post_rst_cnt", {48'h0, stall_cnt}, 64'h1);
        check("post_rst_vld", {63'h0, op_vld_q}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter XLEN, default 32: datapath width in bits.
REQ-002 Parameter NSRC, default 2: number of decode source operands; legal range 1..3.
REQ-003 Parameter CNTW, default 16: width of the stall-cycle statistics counter.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  discard the decode instruction and the operand register contents.
REQ-007 de_valid  in  1  decode-stage instruction valid.
REQ-008 de_rs  in  NSRC*5  source register indices; slot i occupies bits [5i+4:5i].
REQ-009 de_rf_data  in  NSRC*XLEN  register-file read data, one slot per source.
REQ-010 exe_valid, exe_we, exe_is_load  in  1 each  execute-stage valid, writeback enable, load flag.
REQ-011 exe_rd  in  5, and exe_data  in  XLEN  execute-stage destination index and ALU/PC+4 result.
REQ-012 acc_valid, acc_we, acc_is_load  in  1 each  access-stage valid, writeback enable, load flag.
REQ-013 acc_rd  in  5, and acc_data  in  XLEN  access-stage destination index and result.
REQ-014 acc_dvld  in  1  dmem data present on acc_data for an access-stage load.
REQ-015 stall  out  1  freeze PC and decode register (combinational).
REQ-016 op_q  out  NSRC*XLEN  registered execute operands.
REQ-017 op_vld_q  out  1  registered; 0 marks a bubble in execute.
REQ-018 stall_cnt  out  CNTW  saturating count of stalled cycles.

Function
REQ-019 A source slot matches a stage when the stage is valid, we=1, rd==de_rs[i], and rd!=0.
REQ-020 Index 0 never matches; its operand is always de_rf_data[i].
REQ-021 Hazard on slot i: de_valid and (the slot matches exe with exe_is_load=1, or the slot matches acc with acc_is_load=1 and acc_dvld=0 and does not match exe).
REQ-022 stall = OR of all slot hazards AND NOT flush; it is combinational in the same cycle.
REQ-023 Per-slot forward select, highest priority first: exe match with exe_is_load=0 -> exe_data; then acc match -> acc_data; otherwise de_rf_data[i].
REQ-024 The exe stage takes priority over acc when both match (youngest writer wins).
REQ-025 On a clock edge with flush=1: op_vld_q <= 0; op_q is held.
REQ-026 On an edge with stall=1 and flush=0: op_vld_q <= 0 (bubble inserted); op_q is held.
REQ-027 On any other edge: op_q <= the forwarded operands; op_vld_q <= de_valid.
REQ-028 Operand latency is exactly 1 cycle from decode to op_q.
REQ-029 stall_cnt increments by 1 on each edge where stall=1, saturates at 2^CNTW-1, and never wraps.
REQ-030 FSM state RUN: stall=0.
REQ-031 FSM state LU_WAIT: entered when a stall is caused by an exe load; stays while the load sits in acc with acc_dvld=0; returns to RUN on the first cycle with no hazard.
REQ-032 The FSM state is observable only through stall/op_vld_q timing; a flush from any state returns it to RUN.
REQ-033 When de_valid=0, stall=0, forwarding is don't-care, and op_vld_q <= 0.

Reset
REQ-034 While rst=0: op_q=0, op_vld_q=0, stall_cnt=0, FSM state=RUN.
REQ-035 Reset assertion mid-stall clears all state immediately; the first edge after deassertion behaves as RUN.

Structure
REQ-036 Shared package holds the FSM state enum, REG_IDX_W=5, and the opcode-derived we/is_load decode constants used by the pipeline stages.
REQ-037 One sub-module, fwd_mux_slot, is instantiated NSRC times; it contains the per-slot match, priority select, and hazard logic.

Verification
REQ-038 exe ADD x5=0x11, de rs1=x5, rf=0 -> stall=0; next cycle op_q[0]=0x11, op_vld_q=1.
REQ-039 exe and acc both write x7 (0xA / 0xB), de rs2=x7 -> op_q[1]=0xA.
REQ-040 exe LW x3, de rs1=x3, then acc_dvld=0 for 2 cycles then 1 with acc_data=0x55 -> stall=1 for 3 cycles; stall_cnt=3; op_q[0]=0x55 after release.
REQ-041 exe writes x0=0xFF, de rs1=x0, rf=0 -> op_q[0]=0, stall=0.
REQ-042 Load-use stall, then flush=1 -> stall=0, op_vld_q=0, FSM back to RUN.
REQ-043 CNTW=2 with 5 stall cycles -> stall_cnt=3; rst=0 mid-stall -> all outputs 0 asynchronously.
